// File: rtl/accel_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : accel_sample_sequencer
// Purpose  : Owns the accelerometer SPI frame engine. After reset it writes a
//            fixed three-register configuration, then on every sample tick
//            reads the six axis data registers and publishes X/Y/Z together.
//            A watchdog abandons stuck frames and restarts configuration.
// Ports    : clk, reset_n (async, active low)
//            hold                    - freeze: no new sample bursts start
//            xfer_req/cmd/wdata      - frame request to SPI engine
//            xfer_done/rdata         - frame completion and read byte
//            data_x/y/z, data_update - published sample and 1-cycle strobe
//            cfg_done, overrun, err_cnt - status
// Revision : 1.0 - initial release
// ============================================================================
module accel_sample_sequencer #(
  parameter int         SAMPLE_DIV      = 25000000,
  parameter int         TIMEOUT_CYC     = 4000000,
  parameter logic [7:0] CFG_BW_RATE     = 8'h0A,
  parameter logic [7:0] CFG_DATA_FORMAT = 8'h40,
  parameter logic [7:0] CFG_POWER_CTL   = 8'h08
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hold,
  output logic        xfer_req,
  output logic [7:0]  xfer_cmd,
  output logic [7:0]  xfer_wdata,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_rdata,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic [15:0] data_z,
  output logic        data_update,
  output logic        cfg_done,
  output logic        overrun,
  output logic [7:0]  err_cnt
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [2:0] ST_CFG_ISSUE = 3'd0;
  localparam logic [2:0] ST_CFG_WAIT  = 3'd1;
  localparam logic [2:0] ST_IDLE      = 3'd2;
  localparam logic [2:0] ST_RD_ISSUE  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT   = 3'd4;
  localparam logic [2:0] ST_PUBLISH   = 3'd5;
  localparam logic [2:0] ST_RECOVER   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [3:0]        rec_q, rec_d;
  logic [2:0]        idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [5:0][7:0]   shadow_q, shadow_d;
  logic              xfer_req_q, xfer_req_d;
  logic [7:0]        xfer_cmd_q, xfer_cmd_d;
  logic [7:0]        xfer_wdata_q, xfer_wdata_d;
  logic [15:0]       data_x_q, data_x_d, data_y_q, data_y_d, data_z_q, data_z_d;
  logic              data_update_q, data_update_d;
  logic              cfg_done_q, cfg_done_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic tick, in_wait, done_in_wait, timeout, start_burst;

  assign tick         = (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
  assign in_wait      = (state_q == ST_CFG_WAIT) || (state_q == ST_RD_WAIT);
  assign done_in_wait = in_wait && xfer_done;
  // A done arriving in the limit cycle takes precedence over the timeout.
  assign timeout      = in_wait && !xfer_done && (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign start_burst  = (state_q == ST_IDLE) && pending_q && !hold;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_CFG_ISSUE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CFG_ISSUE: state_d = ST_CFG_WAIT;
      ST_CFG_WAIT: begin
        if (xfer_done)    state_d = (idx_q == 3'd2) ? ST_IDLE : ST_CFG_ISSUE;
        else if (timeout) state_d = ST_RECOVER;
      end
      ST_IDLE:      if (start_burst) state_d = ST_RD_ISSUE;
      ST_RD_ISSUE:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (xfer_done)    state_d = (idx_q == 3'd5) ? ST_PUBLISH : ST_RD_ISSUE;
        else if (timeout) state_d = ST_RECOVER;
      end
      ST_PUBLISH:   state_d = ST_IDLE;
      ST_RECOVER:   if (rec_q == 4'd15) state_d = ST_CFG_ISSUE;
      default:      state_d = ST_CFG_ISSUE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
    wd_d          = in_wait ? wd_q + 1'b1 : '0;
    rec_d         = (state_q == ST_RECOVER) ? rec_q + 4'd1 : 4'd0;
    idx_d         = idx_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    shadow_d      = shadow_q;
    xfer_req_d    = xfer_req_q;
    xfer_cmd_d    = xfer_cmd_q;
    xfer_wdata_d  = xfer_wdata_q;
    data_x_d      = data_x_q;
    data_y_d      = data_y_q;
    data_z_d      = data_z_q;
    data_update_d = 1'b0;
    cfg_done_d    = cfg_done_q;
    err_cnt_d     = err_cnt_q;

    if (start_burst) pending_d = 1'b0;
    // Only one tick is ever queued; a second one is flagged, not stored.
    if (tick) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end

    case (state_q)
      ST_CFG_ISSUE: begin
        xfer_req_d = 1'b1;
        case (idx_q)
          3'd0:    begin xfer_cmd_d = 8'h2C; xfer_wdata_d = CFG_BW_RATE;     end
          3'd1:    begin xfer_cmd_d = 8'h31; xfer_wdata_d = CFG_DATA_FORMAT; end
          default: begin xfer_cmd_d = 8'h2D; xfer_wdata_d = CFG_POWER_CTL;   end
        endcase
      end
      ST_IDLE: if (start_burst) idx_d = 3'd0;
      ST_RD_ISSUE: begin
        xfer_req_d   = 1'b1;
        xfer_cmd_d   = 8'hB2 + {5'd0, idx_q};  // read bit | (0x32 + k)
        xfer_wdata_d = 8'h00;
      end
      default: ;
    endcase

    if (done_in_wait) begin
      xfer_req_d = 1'b0;
      if (state_q == ST_CFG_WAIT) begin
        if (idx_q == 3'd2) begin
          idx_d      = 3'd0;
          cfg_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        shadow_d[idx_q] = xfer_rdata;
        if (idx_q == 3'd5) begin
          // Sample and strobe are registered on entry to PUBLISH so the
          // complete set becomes visible in the same cycle as data_update.
          data_x_d      = {shadow_q[1], shadow_q[0]};
          data_y_d      = {shadow_q[3], shadow_q[2]};
          data_z_d      = {xfer_rdata, shadow_q[4]};
          data_update_d = 1'b1;
          idx_d         = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
    end else if (timeout) begin
      xfer_req_d = 1'b0;
      idx_d      = 3'd0;
      shadow_d   = '0;
      cfg_done_d = 1'b0;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q    <= '0;
      wd_q          <= '0;
      rec_q         <= 4'd0;
      idx_q         <= 3'd0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      shadow_q      <= '0;
      xfer_req_q    <= 1'b0;
      xfer_cmd_q    <= 8'h00;
      xfer_wdata_q  <= 8'h00;
      data_x_q      <= 16'h0000;
      data_y_q      <= 16'h0000;
      data_z_q      <= 16'h0000;
      data_update_q <= 1'b0;
      cfg_done_q    <= 1'b0;
      err_cnt_q     <= 8'h00;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      wd_q          <= wd_d;
      rec_q         <= rec_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      shadow_q      <= shadow_d;
      xfer_req_q    <= xfer_req_d;
      xfer_cmd_q    <= xfer_cmd_d;
      xfer_wdata_q  <= xfer_wdata_d;
      data_x_q      <= data_x_d;
      data_y_q      <= data_y_d;
      data_z_q      <= data_z_d;
      data_update_q <= data_update_d;
      cfg_done_q    <= cfg_done_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign xfer_req    = xfer_req_q;
  assign xfer_cmd    = xfer_cmd_q;
  assign xfer_wdata  = xfer_wdata_q;
  assign data_x      = data_x_q;
  assign data_y      = data_y_q;
  assign data_z      = data_z_q;
  assign data_update = data_update_q;
  assign cfg_done    = cfg_done_q;
  assign overrun     = overrun_q;
  assign err_cnt     = err_cnt_q;

endmodule
`default_nettype wire
